// File: rtl/unified_mem_port.sv
// -----------------------------------------------------------------------------
// unified_mem_port
//
// One single-port word memory shared by the instruction-fetch port and the
// data load/store port. A round-robin arbiter picks one requester per
// transaction, a counter models the access latency, and data writes are
// byte-enabled. Each port gets a one-cycle ack pulse so the core can stall.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-low reset
//   i_req    - instruction read request, held until i_ack
//   i_addr   - instruction word address
//   i_rdata  - fetched word, valid with i_ack, held afterwards
//   i_ack    - one-cycle completion pulse, instruction port
//   d_req    - data request, held until d_ack
//   d_we     - 1 = write, 0 = read
//   d_be     - byte enables for writes (bit k -> bits [8k+7:8k])
//   d_addr   - data word address
//   d_wdata  - write data
//   d_rdata  - read data, or merged post-write word; valid with d_ack, held
//   d_ack    - one-cycle completion pulse, data port
//   busy     - high while a transaction is in flight
// -----------------------------------------------------------------------------
module unified_mem_port #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_ack,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_ack,
    output logic                    busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   gnt_data_q, gnt_data_d;    // 1 = data port owns the transaction
    logic                   prio_data_q, prio_data_d;  // 1 = data port wins the next tie
    logic                   we_q, we_d;
    logic [NB-1:0]          be_q, be_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   i_ack_q, i_ack_d;
    logic                   d_ack_q, d_ack_d;
    logic [DATA_WIDTH-1:0]  i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0]  d_rdata_q, d_rdata_d;

    logic                   grant_data;
    logic                   commit;
    logic [IDX_W-1:0]       rd_idx;
    logic [DATA_WIDTH-1:0]  mem_rd_q;
    logic [DATA_WIDTH-1:0]  merged;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    // Upper address bits are deliberately ignored: accesses wrap modulo DEPTH.
    generate
        if (IDX_W < ADDR_WIDTH) begin : g_unused
            logic unused_addr_bits;
            assign unused_addr_bits = ^{i_addr[ADDR_WIDTH-1:IDX_W], d_addr[ADDR_WIDTH-1:IDX_W]};
        end
    endgenerate

    // Byte merge of the stored word with the latched write data.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_merge
            assign merged[8*gi +: 8] = be_q[gi] ? wdata_q[8*gi +: 8] : mem_rd_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_data_d  = gnt_data_q;
        prio_data_d = prio_data_q;
        we_d        = we_q;
        be_d        = be_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        commit      = 1'b0;

        // Data wins when alone, or on a tie when the pointer favours it.
        grant_data  = d_req && (!i_req || prio_data_q);

        // While idle, the RAM is addressed by whichever port would be granted,
        // so the stored word is already registered by the acceptance edge.
        if (state_q == ST_IDLE) begin
            rd_idx = grant_data ? d_addr[IDX_W-1:0] : i_addr[IDX_W-1:0];
        end else begin
            rd_idx = idx_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    gnt_data_d  = grant_data;
                    prio_data_d = !grant_data;
                    we_d        = grant_data && d_we;
                    be_d        = grant_data ? d_be : '0;
                    idx_d       = rd_idx;
                    wdata_d     = d_wdata;
                    cnt_d       = CNT_LOAD;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // The counter holds the number of latency edges still to wait
                // before the commit edge; commit happens when it is already 0,
                // which puts the ack exactly LATENCY edges after acceptance.
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                    if (gnt_data_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = we_q ? merged : mem_rd_q;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = mem_rd_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                // No request sampling here; a still-high req is seen in IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gnt_data_q  <= 1'b0;
            prio_data_q <= 1'b1;
            we_q        <= 1'b0;
            be_q        <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_data_q  <= gnt_data_d;
            prio_data_q <= prio_data_d;
            we_q        <= we_d;
            be_q        <= be_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Memory array: registered read, write only on the commit edge. Reset
    // forces the FSM to IDLE asynchronously, so a pending write never commits.
    always_ff @(posedge clk) begin
        mem_rd_q <= mem[rd_idx];
        if (commit && we_q) begin
            mem[idx_q] <= merged;
        end
    end

    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_unified_mem_port.sv
module tb_unified_mem_port;

    logic        clk;
    logic        rst_n;

    // LATENCY = 2 instance
    logic        i_req, i_ack, d_req, d_we, d_ack, busy;
    logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [1:0]  d_be;

    // LATENCY = 1 instance
    logic        i_req1, i_ack1, d_req1, d_we1, d_ack1, busy1;
    logic [15:0] i_addr1, i_rdata1, d_addr1, d_wdata1, d_rdata1;
    logic [1:0]  d_be1;

    int tests  = 0;
    int errors = 0;

    unified_mem_port #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(1024), .LATENCY(2)) dut (
        .clk(clk), .reset(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .busy(busy)
    );

    unified_mem_port #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rst_n),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ack(i_ack1),
        .d_req(d_req1), .d_we(d_we1), .d_be(d_be1), .d_addr(d_addr1),
        .d_wdata(d_wdata1), .d_rdata(d_rdata1), .d_ack(d_ack1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One data transaction on either instance; returns read data and the
    // number of rising edges from request to observed ack (E0 counts as 1).
    task automatic data_txn(input bit sel, input logic we, input logic [1:0] be,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            output logic [15:0] rdata, output int lat);
        bit got;
        @(negedge clk);
        if (sel) begin
            d_req1 = 1'b1; d_we1 = we; d_be1 = be; d_addr1 = addr; d_wdata1 = wdata;
        end else begin
            d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        end
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if ((sel ? d_ack1 : d_ack) === 1'b1) got = 1'b1;
        end
        rdata = sel ? d_rdata1 : d_rdata;
        if (!got) lat = -1;
        // Scramble inputs after the ack: the accepted transaction must not care.
        if (sel) begin
            d_req1 = 1'b0; d_wdata1 = 16'h5A5A;
        end else begin
            d_req = 1'b0; d_wdata = 16'h5A5A;
        end
        @(negedge clk);
        check("ack_one_cycle", {31'd0, (sel ? d_ack1 : d_ack)}, 32'd0);
    endtask

    task automatic instr_txn(input logic [15:0] addr, output logic [15:0] rdata, output int lat);
        bit got;
        @(negedge clk);
        i_req = 1'b1; i_addr = addr;
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (i_ack === 1'b1) got = 1'b1;
        end
        rdata = i_rdata;
        if (!got) lat = -1;
        i_req = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[9];
    logic [15:0] rd;
    int          lat;

    initial begin
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        i_req1 = 0; i_addr1 = 0; d_req1 = 0; d_we1 = 0; d_be1 = 0; d_addr1 = 0; d_wdata1 = 0;

        vecs[0] = '{1'b1, 2'b11, 16'h0005, 16'hBEEF, 16'hBEEF};
        vecs[1] = '{1'b0, 2'b00, 16'h0005, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b1, 2'b11, 16'h0007, 16'h1234, 16'h1234};
        vecs[3] = '{1'b1, 2'b01, 16'h0007, 16'hAACD, 16'h12CD};
        vecs[4] = '{1'b1, 2'b00, 16'h0007, 16'hFFFF, 16'h12CD};
        vecs[5] = '{1'b0, 2'b00, 16'h0007, 16'h0000, 16'h12CD};
        vecs[6] = '{1'b1, 2'b10, 16'h0007, 16'h5678, 16'h56CD};
        vecs[7] = '{1'b1, 2'b11, 16'h0403, 16'h00FF, 16'h00FF};
        vecs[8] = '{1'b0, 2'b00, 16'h0003, 16'h0000, 16'h00FF};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",    {31'd0, busy},  32'd0);
        check("rst_i_ack",   {31'd0, i_ack}, 32'd0);
        check("rst_d_ack",   {31'd0, d_ack}, 32'd0);
        check("rst_i_rdata", {16'd0, i_rdata}, 32'd0);
        check("rst_d_rdata", {16'd0, d_rdata}, 32'd0);
        rst_n = 1'b1;

        // ---------------- table-driven data transactions (LATENCY=2) ----------------
        for (int v = 0; v < 9; v++) begin
            data_txn(1'b0, vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata, rd, lat);
            check($sformatf("vec%0d_rdata", v), {16'd0, rd}, {16'd0, vecs[v].exp});
            check($sformatf("vec%0d_latency", v), lat, 32'd3);
            $display("[TB] vec %0d we=%0b be=%b addr=%h wdata=%h -> rdata=%h edges=%0d",
                     v, vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata, rd, lat);
        end

        // Shared array + wrap: fetch sees data written through the data port.
        instr_txn(16'h0003, rd, lat);
        check("ifetch_wrap_rdata", {16'd0, rd}, 32'h00FF);
        check("ifetch_latency", lat, 32'd3);
        $display("[TB] ifetch addr=0003 -> %h edges=%0d", rd, lat);
        instr_txn(16'h0005, rd, lat);
        check("ifetch5_rdata", {16'd0, rd}, 32'hBEEF);
        check("d_rdata_held", {16'd0, d_rdata}, 32'h00FF);
        $display("[TB] ifetch addr=0005 -> %h", rd);

        // ---------------- simultaneous requests after reset ----------------
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        begin
            int n_acks;
            int last;
            int low_cnt;
            bit overlap;
            i_req = 1; i_addr = 16'h0007; d_req = 1; d_we = 0; d_addr = 16'h0005;
            n_acks = 0; last = 0; low_cnt = 0; overlap = 0;
            for (int c = 0; c < 60 && n_acks < 4; c++) begin
                @(negedge clk);
                if (i_ack && d_ack) overlap = 1;
                if (!busy) low_cnt++;
                if (i_ack || d_ack) begin
                    check($sformatf("arb_order%0d", n_acks), {31'd0, d_ack},
                          (n_acks % 2 == 0) ? 32'd1 : 32'd0);
                    if (d_ack) check("arb_d_rdata", {16'd0, d_rdata}, 32'hBEEF);
                    else       check("arb_i_rdata", {16'd0, i_rdata}, 32'h56CD);
                    if (n_acks > 0) begin
                        check("arb_spacing", c - last, 32'd4);
                        check("arb_busy_gap", low_cnt, 32'd1);
                    end
                    $display("[TB] arb ack %0d port=%s cycle=%0d", n_acks, d_ack ? "data" : "instr", c);
                    low_cnt = 0;
                    last = c;
                    n_acks++;
                    if (n_acks == 4) begin
                        i_req = 0; d_req = 0;
                    end
                end
            end
            i_req = 0; d_req = 0;
            check("arb_ack_count", n_acks, 32'd4);
            check("arb_no_overlap", {31'd0, overlap}, 32'd0);
        end

        // ---------------- reset while ack is high ----------------
        @(negedge clk);
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 16'h0005;
        begin
            bit got;
            got = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (d_ack) got = 1;
            end
            check("rst_ack_seen", {31'd0, got}, 32'd1);
            rst_n = 1'b0;
            #1;
            check("rst_ack_drop", {31'd0, d_ack}, 32'd0);
            check("rst_rdata_clear", {16'd0, d_rdata}, 32'd0);
            d_req = 0;
            $display("[TB] reset during ack: d_ack=%0b d_rdata=%h", d_ack, d_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- reset before write commit ----------------
        data_txn(1'b0, 1'b1, 2'b11, 16'h0009, 16'h0001, rd, lat);
        check("mid_prewrite", {16'd0, rd}, 32'h0001);
        @(negedge clk);
        d_req = 1; d_we = 1; d_be = 2'b11; d_addr = 16'h0009; d_wdata = 16'hFFFF;
        @(negedge clk);                 // after E0
        check("mid_busy_inflight", {31'd0, busy}, 32'd1);
        @(posedge clk);                 // E0+1
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_busy_drop", {31'd0, busy}, 32'd0);
        check("mid_ack_drop", {31'd0, d_ack}, 32'd0);
        d_req = 0; d_we = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_idle_after", {31'd0, busy}, 32'd0);
        data_txn(1'b0, 1'b0, 2'b00, 16'h0009, 16'h0000, rd, lat);
        check("mid_mem_kept", {16'd0, rd}, 32'h0001);
        $display("[TB] after aborted write mem[9]=%h", rd);

        // ---------------- LATENCY=1 instance ----------------
        for (int a = 0; a < 3; a++) begin
            data_txn(1'b1, 1'b1, 2'b11, 16'(a), 16'hA000 + 16'(a), rd, lat);
            check($sformatf("l1_write%0d_latency", a), lat, 32'd2);
            $display("[TB] L1 write addr=%0d -> %h edges=%0d", a, rd, lat);
        end
        @(negedge clk);
        d_req1 = 1; d_we1 = 0; d_addr1 = 16'h0000;
        begin
            int n;
            int last;
            n = 0; last = 0;
            for (int c = 0; c < 40 && n < 3; c++) begin
                @(negedge clk);
                if (d_ack1) begin
                    check($sformatf("l1_read%0d_rdata", n), {16'd0, d_rdata1}, 32'hA000 + n);
                    if (n == 0) check("l1_first_latency", c, 32'd1);
                    else        check("l1_spacing", c - last, 32'd3);
                    $display("[TB] L1 read %0d rdata=%h cycle=%0d", n, d_rdata1, c);
                    last = c;
                    n++;
                    d_addr1 = 16'(n);
                    if (n == 3) d_req1 = 0;
                end
            end
            d_req1 = 0;
            check("l1_read_count", n, 32'd3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
